// File: rtl/key_pkg.sv
// Shared definitions for the key front end: debounce channel state encoding and board timing constants.
package key_pkg;

  localparam int CLK_FREQ_HZ          = 50_000_000;
  localparam int DEBOUNCE_CYC_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    UP      = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_debounce_decoder_if.sv
// Key bundle between the pins/bench (master) and the debounce front end (slave).
interface key_debounce_decoder_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_db;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [1:0]        key_code;
  logic              key_valid;

  modport master (
    output key_raw,
    input  key_db, key_press, key_release, key_code, key_valid
  );

  modport slave (
    input  key_raw,
    output key_db, key_press, key_release, key_code, key_valid
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, four-state debounce FSM with restartable counter,
// registered active-low level plus press/release pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int CNT_W        = 20,
  parameter int SYNC_STAGES  = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_db,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;
  key_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_d, press_d, release_d;

  // Synchroniser idles high so a reset looks like "no key pressed".
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain really delays.
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  assign key_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= UP;
      cnt_q       <= '0;
      key_db      <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_db      <= db_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    db_d      = key_db;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      UP: begin
        if (!key_s) begin
          state_d = FILT_DN;
          cnt_d   = '0;
        end
      end
      FILT_DN: begin
        if (key_s) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
          db_d    = 1'b0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (key_s) begin
          state_d = FILT_UP;
          cnt_d   = '0;
        end
      end
      FILT_UP: begin
        if (!key_s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = UP;
          cnt_d     = '0;
          db_d      = 1'b1;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_debounce_decoder.sv
// Four-key front end: one debounce channel per key plus a registered priority encoder
// (lowest index wins) producing key_code/key_valid one cycle after key_db.
module key_debounce_decoder
  import key_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int CNT_W        = 20,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  key_debounce_decoder_if.slave  bus
);

  logic [N_KEYS-1:0] db, press, release_p;
  logic [1:0]        code_d, code_q;
  logic              valid_d, valid_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_raw     (bus.key_raw[g]),
      .key_db      (db[g]),
      .key_press   (press[g]),
      .key_release (release_p[g])
    );
  end

  // Scan high-to-low so the lowest-numbered pressed key is written last and wins.
  always_comb begin
    code_d = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (!db[i]) code_d = 2'(i);
    end
    valid_d = ~&db;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign bus.key_db      = db;
  assign bus.key_press   = press;
  assign bus.key_release = release_p;
  assign bus.key_code    = code_q;
  assign bus.key_valid   = valid_q;

endmodule

// File: tb/tb_key_debounce_decoder.sv
// Bench for key_debounce_decoder: directed scenarios plus random key bouncing, checked every
// cycle against a run-length model of the debounce rules.
module tb_key_debounce_decoder;

  localparam int NK  = 4;
  localparam int DB  = 16;
  localparam int SS  = 2;
  localparam int LAT = SS + DB;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 sys_clk = ~sys_clk;

  key_debounce_decoder_if #(.N_KEYS(NK)) bus ();

  key_debounce_decoder #(
    .N_KEYS       (NK),
    .DEBOUNCE_CYC (DB),
    .CNT_W        (5),
    .SYNC_STAGES  (SS)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a key's level flips once the synchronised input has differed from it
  // for DB+1 consecutive samples (one sample to leave the stable state, DB to count).
  logic [NK-1:0] raw_q[$];
  logic [NK-1:0] m_prev, m_db, m_press, m_rel;
  int            m_run[NK];
  logic [1:0]    m_code;
  logic          m_valid;

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      raw_q = {};
      for (int i = 0; i < SS; i++) raw_q.push_back('1);
      m_prev = '1; m_db = '1; m_press = '0; m_rel = '0;
      m_code = '0; m_valid = 1'b0;
      for (int i = 0; i < NK; i++) m_run[i] = 0;
    end else begin
      logic [NK-1:0] s;
      s = raw_q.pop_front();
      raw_q.push_back(bus.key_raw);
      m_valid = (m_db != '1);
      m_code  = 2'd0;
      for (int i = 0; i < NK; i++)
        if (!m_db[i]) begin m_code = 2'(i); break; end
      m_press = '0; m_rel = '0;
      for (int i = 0; i < NK; i++) begin
        if (s[i] == m_prev[i]) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : 1000;
        else                   m_run[i] = 1;
        if (s[i] != m_db[i] && m_run[i] == DB + 1) begin
          m_db[i] = s[i];
          if (s[i]) m_rel[i] = 1'b1; else m_press[i] = 1'b1;
        end
      end
      m_prev = s;
    end
  end

  always @(negedge sys_clk) begin
    check("model_db",      32'(bus.key_db),      32'(m_db));
    check("model_press",   32'(bus.key_press),   32'(m_press));
    check("model_release", 32'(bus.key_release), 32'(m_rel));
    check("model_code",    32'(bus.key_code),    32'(m_code));
    check("model_valid",   32'(bus.key_valid),   32'(m_valid));
  end

  // Observed-activity accumulators for the directed scenarios.
  int   press_cnt[NK];
  int   rel_cnt[NK];
  logic valid_seen, db_changed;

  always @(posedge sys_clk) begin
    #2;
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] += int'(bus.key_press[i]);
      rel_cnt[i]   += int'(bus.key_release[i]);
    end
    if (bus.key_valid) valid_seen = 1'b1;
    if (bus.key_db != '1) db_changed = 1'b1;
  end

  task automatic clear_acc();
    for (int i = 0; i < NK; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    valid_seen = 1'b0;
    db_changed = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Counts cycles from the drive edge until the pulse shows; -1 on timeout.
  task automatic wait_pulse(input int idx, input bit rel, output int lat);
    lat = -1;
    for (int k = 1; k <= LAT + 10; k++) begin
      @(negedge sys_clk);
      if ((rel ? bus.key_release[idx] : bus.key_press[idx]) === 1'b1) begin
        lat = k - 1;
        return;
      end
    end
  endtask

  int lat;
  int hold[NK];

  initial begin
    bus.key_raw = '1;
    clear_acc();

    // 1 reset
    wait_cyc(3);
    check("rst_db",      32'(bus.key_db),      32'hF);
    check("rst_press",   32'(bus.key_press),   32'h0);
    check("rst_release", 32'(bus.key_release), 32'h0);
    check("rst_code",    32'(bus.key_code),    32'h0);
    check("rst_valid",   32'(bus.key_valid),   32'h0);
    sys_rst = 1'b1;
    wait_cyc(3);

    // 2 clean press
    bus.key_raw[0] = 1'b0;
    wait_pulse(0, 1'b0, lat);
    check("press0_lat", 32'(lat), 32'(LAT));
    check("press0_db",  32'(bus.key_db), 32'hE);
    wait_cyc(1);
    check("press0_width", 32'(bus.key_press), 32'h0);
    check("press0_code",  32'(bus.key_code),  32'h0);
    check("press0_valid", 32'(bus.key_valid), 32'h1);
    wait_cyc(20);
    bus.key_raw[0] = 1'b1;
    wait_pulse(0, 1'b1, lat);
    check("release0_lat", 32'(lat), 32'(LAT));
    wait_cyc(5);

    // 3 bounce
    clear_acc();
    bus.key_raw[1] = 1'b0; wait_cyc(10);
    bus.key_raw[1] = 1'b1; wait_cyc(3);
    bus.key_raw[1] = 1'b0;
    wait_pulse(1, 1'b0, lat);
    check("bounce_lat", 32'(lat), 32'(LAT));
    wait_cyc(12);
    check("bounce_npress", 32'(press_cnt[1]), 32'd1);
    bus.key_raw[1] = 1'b1;
    wait_cyc(LAT + 5);

    // 4 glitch
    clear_acc();
    bus.key_raw[2] = 1'b0; wait_cyc(12);
    bus.key_raw[2] = 1'b1; wait_cyc(30);
    check("glitch_db_moved", 32'(db_changed), 32'd0);
    check("glitch_press",    32'(press_cnt[2]), 32'd0);
    check("glitch_valid",    32'(valid_seen), 32'd0);

    // 5 simultaneous
    bus.key_raw[3:2] = 2'b00;
    wait_pulse(2, 1'b0, lat);
    check("simul_lat",   32'(lat), 32'(LAT));
    check("simul_press", 32'(bus.key_press), 32'hC);
    wait_cyc(1);
    check("simul_code",  32'(bus.key_code),  32'd2);
    check("simul_valid", 32'(bus.key_valid), 32'd1);
    wait_cyc(5);
    bus.key_raw[2] = 1'b1;
    wait_pulse(2, 1'b1, lat);
    check("simul_rel_lat", 32'(lat), 32'(LAT));
    check("simul_release", 32'(bus.key_release), 32'h4);
    wait_cyc(1);
    check("simul_code3", 32'(bus.key_code), 32'd3);
    bus.key_raw[3] = 1'b1;
    wait_cyc(LAT + 5);
    check("idle_valid", 32'(bus.key_valid), 32'd0);
    check("idle_code",  32'(bus.key_code),  32'd0);

    // 6 reset mid-filter
    bus.key_raw[0] = 1'b0;
    wait_cyc(SS + 10);
    sys_rst = 1'b0;
    wait_cyc(1);
    check("midrst_db", 32'(bus.key_db), 32'hF);
    wait_cyc(2);
    sys_rst = 1'b1;
    wait_pulse(0, 1'b0, lat);
    check("midrst_lat", 32'(lat), 32'(LAT));
    bus.key_raw[0] = 1'b1;
    wait_cyc(LAT + 5);

    // random bouncing on all keys, checked by the model every cycle
    for (int i = 0; i < NK; i++) hold[i] = 0;
    repeat (3000) begin
      @(negedge sys_clk);
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          bus.key_raw[i] = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 40));
        end else begin
          hold[i]--;
        end
      end
    end
    bus.key_raw = '1;
    wait_cyc(LAT + 5);
    check("final_db", 32'(bus.key_db), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
